// File: rtl/dmem_host_pkg.sv
// Shared types and defaults for the data-memory host port.
package dmem_host_pkg;

  localparam int unsigned HOST_AW      = 8;
  localparam int unsigned HOST_DW      = 8;
  localparam int unsigned HOST_TW      = 16;
  localparam logic [15:0] HOST_TIMEOUT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DUMP  = 3'd3,
    ST_DRAIN = 3'd4
  } host_state_e;

  // Transfer length: 0..2**AW inclusive needs one extra bit.
  typedef logic [HOST_AW:0] host_len_t;

endpackage

// File: rtl/dmem_host_port_if.sv
// Host port bundle: job control, byte streams, dat_mem port and core control.
interface dmem_host_port_if
  import dmem_host_pkg::*;
#(
  parameter int unsigned AW = HOST_AW,
  parameter int unsigned DW = HOST_DW
);

  logic          start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_len;
  logic [AW-1:0] dump_base;
  logic [AW:0]   dump_len;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          core_done;
  logic          core_reset;
  logic          host_sel;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data;
  logic          busy;
  logic          timeout;

  modport master (
    output start, load_base, load_len, dump_base, dump_len,
    output in_valid, in_data, out_ready, core_done, mem_rd_data,
    input  in_ready, out_valid, out_data, out_last, core_reset, host_sel,
    input  mem_wr_en, mem_addr, mem_wr_data, busy, timeout
  );

  modport slave (
    input  start, load_base, load_len, dump_base, dump_len,
    input  in_valid, in_data, out_ready, core_done, mem_rd_data,
    output in_ready, out_valid, out_data, out_last, core_reset, host_sel,
    output mem_wr_en, mem_addr, mem_wr_data, busy, timeout
  );

endinterface

// File: rtl/host_wdog.sv
// Run-phase watchdog: counts while enabled, holds at LIMIT, flags terminal count.
module host_wdog #(
  parameter int unsigned   TW    = 16,
  parameter logic [TW-1:0] LIMIT = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [TW-1:0] o_count,
  output logic          o_tc_c
);

  logic [TW-1:0] r_count;

  // Counter: clear has priority, saturates at LIMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc_c  = (r_count == LIMIT);

endmodule

// File: rtl/dmem_host_port.sv
// Host side of the data memory: loads a byte block, runs the core, dumps a window.
module dmem_host_port
  import dmem_host_pkg::*;
#(
  parameter int unsigned   AW      = HOST_AW,
  parameter int unsigned   DW      = HOST_DW,
  parameter int unsigned   TW      = HOST_TW,
  parameter logic [TW-1:0] TIMEOUT = TW'(HOST_TIMEOUT)
) (
  input logic             clk,
  input logic             reset,
  dmem_host_port_if.slave bus
);

  localparam logic [2:0] IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] LOAD  = 3'(ST_LOAD);
  localparam logic [2:0] RUN   = 3'(ST_RUN);
  localparam logic [2:0] DUMP  = 3'(ST_DUMP);
  localparam logic [2:0] DRAIN = 3'(ST_DRAIN);

  logic [2:0]    r_state,     w_state_nxt;
  logic [AW-1:0] r_addr,      w_addr_nxt;
  logic [AW:0]   r_cnt,       w_cnt_nxt;
  logic [AW-1:0] r_dump_base, w_dump_base_nxt;
  logic [AW:0]   r_dump_len,  w_dump_len_nxt;
  logic [DW-1:0] r_out_data,  w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          r_out_last,  w_out_last_nxt;
  logic          r_timeout,   w_timeout_nxt;

  logic          w_in_ready;
  logic          w_wr;
  logic          w_run;
  logic          w_done_ok;
  logic          w_wd_tc;
  logic [TW-1:0] w_wd_count;

  assign w_run      = (r_state == RUN);
  assign w_in_ready = (r_state == LOAD) && (r_cnt != '0);
  assign w_wr       = bus.in_valid && w_in_ready;
  // Count is zero only in the first RUN cycle, which masks a stale done level.
  assign w_done_ok  = bus.core_done && (w_wd_count != '0);

  host_wdog #(
    .TW    (TW),
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (!w_run),
    .i_en    (w_run),
    .o_count (w_wd_count),
    .o_tc_c  (w_wd_tc)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_dump_base <= '0;
      r_dump_len  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dump_base <= w_dump_base_nxt;
      r_dump_len  <= w_dump_len_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // Next-state and datapath update for load, run, dump and drain phases.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_cnt_nxt       = r_cnt;
    w_dump_base_nxt = r_dump_base;
    w_dump_len_nxt  = r_dump_len;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    w_timeout_nxt   = r_timeout;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_dump_base_nxt = bus.dump_base;
          w_dump_len_nxt  = bus.dump_len;
          w_timeout_nxt   = 1'b0;
          w_addr_nxt      = bus.load_base;
          w_cnt_nxt       = bus.load_len;
          w_state_nxt     = (bus.load_len != '0) ? LOAD : RUN;
        end
      end
      LOAD: begin
        if (w_wr) begin
          w_addr_nxt = r_addr + AW'(1);
          w_cnt_nxt  = r_cnt - (AW+1)'(1);
          if (r_cnt == (AW+1)'(1)) begin
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_done_ok || w_wd_tc) begin
          w_timeout_nxt = !w_done_ok;
          w_addr_nxt    = r_dump_base;
          w_cnt_nxt     = r_dump_len;
          w_state_nxt   = (r_dump_len != '0) ? DUMP : IDLE;
        end
      end
      DUMP: begin
        if ((r_cnt != '0) && (!r_out_valid || bus.out_ready)) begin
          w_out_data_nxt  = bus.mem_rd_data;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = (r_cnt == (AW+1)'(1));
          w_addr_nxt      = r_addr + AW'(1);
          w_cnt_nxt       = r_cnt - (AW+1)'(1);
          if (r_cnt == (AW+1)'(1)) begin
            w_state_nxt = DRAIN;
          end
        end else if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.mem_wr_en   = w_wr;
  assign bus.mem_wr_data = bus.in_data;
  assign bus.mem_addr    = r_addr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;
  assign bus.core_reset  = !w_run;
  assign bus.host_sel    = !w_run;
  assign bus.busy        = (r_state != IDLE);
  assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_dmem_host_port.sv
// Randomized scoreboard bench for dmem_host_port with a byte-array memory model.
module tb_dmem_host_port;
  import dmem_host_pkg::*;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned TW    = 16;
  localparam int          TO    = 20;
  localparam int          DEPTH = 256;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  dmem_host_port_if #(.AW(AW), .DW(DW)) bus ();

  dmem_host_port #(
    .AW      (AW),
    .DW      (DW),
    .TW      (TW),
    .TIMEOUT (16'd20)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] dmem    [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  assign bus.mem_rd_data = dmem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_wr_en) dmem[bus.mem_addr] <= bus.mem_wr_data;

  typedef struct packed { logic [7:0] data; logic last; } out_exp_t;
  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_exp_t;

  out_exp_t   out_q[$];
  wr_exp_t    wr_q[$];
  logic [7:0] load_bytes[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Monitor: pops expected writes/outputs when the DUT presents them.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    out_exp_t e;
    wr_exp_t  w;
    if (reset) begin
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (out_q.size() == 0) check("extra_out", bus.out_valid, 0);
        else begin
          e = out_q.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_last", bus.out_last, e.last);
        end
      end
      if (bus.mem_wr_en) begin
        check("wr_host_sel", bus.host_sel, 1);
        if (wr_q.size() == 0) check("extra_write", bus.mem_wr_en, 0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", bus.mem_addr, w.addr);
          check("wr_data", bus.mem_wr_data, w.data);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},   bus.in_ready,   0);
    check({tag, "_out_valid"},  bus.out_valid,  0);
    check({tag, "_out_last"},   bus.out_last,   0);
    check({tag, "_out_data"},   bus.out_data,   0);
    check({tag, "_core_reset"}, bus.core_reset, 1);
    check({tag, "_host_sel"},   bus.host_sel,   1);
    check({tag, "_mem_wr_en"},  bus.mem_wr_en,  0);
    check({tag, "_mem_addr"},   bus.mem_addr,   0);
    check({tag, "_busy"},       bus.busy,       0);
    check({tag, "_timeout"},    bus.timeout,    0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (bus.busy && guard < 5000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("idle_before_start", bus.busy, 0);
  endtask

  // rmode: 0 random in_valid/out_ready, 1 full rate, 2 out_ready toggling.
  task automatic run_job(input int lbase, input int llen, input int dbase, input int dlen,
                         input int done_at, input int rmode, input bit use_fixed);
    int idx, guard, rc, dc, exp_rc;
    bit hs, exp_to, tog;
    wait_idle();
    if (!use_fixed) begin
      load_bytes.delete();
      for (int i = 0; i < llen; i++) load_bytes.push_back(8'($urandom));
    end
    bus.load_base = 8'(lbase);
    bus.load_len  = host_len_t'(llen);
    bus.dump_base = 8'(dbase);
    bus.dump_len  = host_len_t'(dlen);
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("timeout_cleared", bus.timeout, 0);
    check("busy_after_start", bus.busy, 1);
    check("core_reset_after_start", bus.core_reset, (llen == 0) ? 0 : 1);

    idx = 0; guard = 0;
    while (idx < llen && guard < 5000) begin
      bus.in_valid = (rmode == 1) ? 1'b1 : ($urandom_range(3) != 0);
      bus.in_data  = load_bytes[idx];
      hs = bus.in_valid && bus.in_ready;
      if (hs) begin
        wr_q.push_back(wr_exp_t'{addr: 8'(lbase + idx), data: load_bytes[idx]});
        ref_mem[8'(lbase + idx)] = load_bytes[idx];
      end
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    check("load_complete", idx, llen);
    if (rmode == 1) check("load_cycles", guard, llen);

    for (int i = 0; i < dlen; i++)
      out_q.push_back(out_exp_t'{data: ref_mem[8'(dbase + i)], last: (i == dlen - 1)});

    rc = 0; guard = 0;
    while (bus.core_reset == 1'b0 && guard < TO + 10) begin
      rc++;
      bus.core_done = (done_at != 0) && (rc >= done_at);
      bus.in_valid  = 1'($urandom);
      bus.in_data   = 8'($urandom);
      check("run_host_sel", bus.host_sel, 0);
      @(posedge clk); #1;
      guard++;
    end
    bus.core_done = 1'b0;
    bus.in_valid  = 1'b0;
    exp_to = !((done_at != 0) && (imax(done_at, 2) <= TO + 1));
    exp_rc = exp_to ? TO + 1 : imax(done_at, 2);
    check("run_cycles", rc, exp_rc);
    check("timeout_flag", bus.timeout, exp_to);
    if (dlen == 0) check("idle_after_zero_dump", bus.busy, 0);

    dc = 0; guard = 0; tog = 1'b0;
    while (bus.busy && guard < 5000) begin
      case (rmode)
        1:       bus.out_ready = 1'b1;
        2:       begin bus.out_ready = tog; tog = ~tog; end
        default: bus.out_ready = ($urandom_range(2) != 0);
      endcase
      @(posedge clk); #1;
      dc++; guard++;
    end
    if (rmode == 1) check("dump_cycles", dc, (dlen == 0) ? 0 : dlen + 1);
    check("out_queue_drained", out_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    check("end_out_valid", bus.out_valid, 0);
    check("end_core_reset", bus.core_reset, 1);
    bus.out_ready = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int idx, guard, lb, ll, db, dl;
    bit hs;
    for (int i = 0; i < DEPTH; i++) begin dmem[i] = 8'h00; ref_mem[i] = 8'h00; end
    bus.start = 0; bus.load_base = 0; bus.load_len = 0; bus.dump_base = 0; bus.dump_len = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0; bus.core_done = 0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed: load then dump with known bytes.
    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_job(8'h10, 4, 8'h10, 4, 5, 1, 1'b1);
    // Address wrap.
    run_job(8'hFE, 3, 8'hFE, 3, 3, 1, 1'b0);
    // Backpressure on a 3-byte dump.
    run_job(8'h30, 3, 8'h30, 3, 4, 2, 1'b0);
    // Watchdog expiry, then a job whose start must clear timeout.
    run_job(8'h50, 2, 8'h50, 2, 0, 0, 1'b0);
    run_job(8'h60, 0, 8'h50, 2, 2, 1, 1'b0);
    // Zero lengths.
    run_job(8'h70, 0, 8'h70, 0, 3, 1, 1'b0);
    // Stale done held from the first RUN cycle.
    run_job(8'h80, 1, 8'h80, 1, 1, 1, 1'b0);
    // Done and watchdog on the same cycle.
    run_job(8'h90, 2, 8'h90, 2, TO + 1, 0, 1'b0);
    // Full-depth load and dump.
    run_job(int'($urandom_range(255)), 256, int'($urandom_range(255)), 256, 6, 1, 1'b0);

    for (int j = 0; j < 16; j++) begin
      lb = int'($urandom_range(255));
      ll = int'($urandom_range(40));
      db = ($urandom_range(1) == 0) ? lb : int'($urandom_range(255));
      dl = int'($urandom_range(40));
      run_job(lb, ll, db, dl, int'($urandom_range(24)), int'($urandom_range(2)), 1'b0);
    end

    // Mid-load reset after two of four bytes.
    wait_idle();
    load_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    bus.load_base = 8'h40; bus.load_len = 9'd4; bus.dump_base = 8'h40; bus.dump_len = 9'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    idx = 0; guard = 0;
    bus.in_valid = 1'b1;
    while (idx < 2 && guard < 20) begin
      bus.in_data = load_bytes[idx];
      hs = bus.in_valid && bus.in_ready;
      if (hs) begin
        wr_q.push_back(wr_exp_t'{addr: 8'(8'h40 + idx), data: load_bytes[idx]});
        ref_mem[8'(8'h40 + idx)] = load_bytes[idx];
      end
      @(posedge clk); #1;
      if (hs) idx++;
      guard++;
    end
    check("partial_load_count", idx, 2);
    bus.in_data = load_bytes[2];
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    bus.in_valid = 1'b0;
    out_q.delete();
    wr_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_job(8'h40, 4, 8'h40, 4, 3, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_host_port.md
Name: dmem_host_port

Overview:
- Host-side counterpart of the processor's data memory. Streams an input byte block into dat_mem while the core is held in reset, then releases the core.
- Waits for the core's done flag (with a watchdog), then streams a result window back out of dat_mem.
- Sits beside the processor top level. While host_sel=1 a top-level mux gives this block ownership of the dat_mem write/address port; otherwise the core owns it.

Parameters:
- AW, 8, data memory address width (depth 2**AW).
- DW, 8, data width.
- TW, 16, watchdog counter width.
- TIMEOUT, 16'hFFFF, maximum RUN cycles before a forced dump.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  one-cycle pulse, accepted only in IDLE.
- load_base  in  AW  first dat_mem address written; sampled on start.
- load_len  in  AW+1  bytes to load, 0..2**AW; sampled on start.
- dump_base  in  AW  first address read back; sampled on start.
- dump_len  in  AW+1  bytes to dump, 0..2**AW; sampled on start.
- in_valid  in  1  input byte valid.
- in_data  in  DW  input byte.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  out_data valid.
- out_data  out  DW  dumped byte.
- out_last  out  1  final dump byte, qualified by out_valid.
- out_ready  in  1  sink accepts out_data.
- core_done  in  1  processor done flag (level).
- core_reset  out  1  active-high reset to the processor (drives its reset).
- host_sel  out  1  1 = this block owns dat_mem port.
- mem_wr_en  out  1  dat_mem write strobe.
- mem_addr  out  AW  dat_mem address.
- mem_wr_data  out  DW  dat_mem write data.
- mem_rd_data  in  DW  dat_mem combinational read data at mem_addr.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky: last run hit watchdog; cleared on next accepted start.

Behaviour:
- Reset values:
  - state=IDLE, in_ready=0, out_valid=0, out_last=0, out_data=0.
  - core_reset=1, host_sel=1, mem_wr_en=0, mem_addr=0, busy=0, timeout=0.
- States: IDLE, LOAD, RUN, DUMP, DRAIN.
- IDLE:
  - core_reset=1, host_sel=1.
  - start=1 latches bases/lengths, clears timeout, addr<=load_base, cnt<=load_len.
  - Go to LOAD if load_len!=0, else RUN.
- LOAD:
  - in_ready=1 combinationally while cnt!=0.
  - Transfer on in_valid&in_ready: mem_wr_en=1 the same cycle, mem_addr=addr, mem_wr_data=in_data. Then addr<=addr+1 (mod 2**AW), cnt<=cnt-1.
  - On the transfer that makes cnt 0, go to RUN. No extra cycle; one byte per cycle sustained.
- RUN:
  - core_reset=0, host_sel=0, in_ready=0, mem_wr_en=0.
  - Watchdog counts from 0 each cycle.
  - If core_done=1 (checked from the 2nd RUN cycle onward, so a stale done cannot fire), go to DUMP.
  - Otherwise, if watchdog==TIMEOUT, set timeout=1 and go to DUMP.
  - If both happen the same cycle, core_done wins and timeout stays 0.
- DUMP entry: core_reset=1, host_sel=1, addr<=dump_base, cnt<=dump_len. If dump_len==0, go straight to IDLE.
- DUMP:
  - mem_addr=addr.
  - When cnt!=0 and (out_valid==0 or out_ready==1): out_data<=mem_rd_data, out_valid<=1, out_last<=(cnt==1), addr<=addr+1, cnt<=cnt-1.
  - If the output register is not reloaded and out_ready=1, out_valid<=0.
  - When cnt reaches 0, go to DRAIN.
  - Sustains one byte per cycle when out_ready stays high.
- DRAIN: hold out_data/out_valid until out_ready. On the handshake of the last byte, out_valid<=0 and go to IDLE.
- Handshakes:
  - out_valid never drops and out_data never changes while out_valid=1 and out_ready=0.
  - in_valid is ignored outside LOAD.
- Address wrap: base+len past 2**AW-1 wraps to 0. A length of 2**AW touches every address exactly once.
- start outside IDLE is ignored.
- Reset mid-operation: all outputs return to reset values immediately. A partial load is not rolled back; the dat_mem contents are undefined to the host.

Decomposition:
- Package dmem_host_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DUMP, DRAIN);
  - a length-type typedef of AW+1 bits;
  - the default TIMEOUT constant.
- One sub-module, host_wdog: a TW-bit watchdog counter with clear, enable and a terminal-count output. Everything else stays in dmem_host_port.

Test Plan:
- Load then dump.
  - Stimulus: load_base=8'h10, load_len=4, bytes 11,22,33,44; core_done 5 cycles into RUN; dump_base=8'h10, dump_len=4, out_ready=1.
  - Response: writes at 10..13; out_data 11,22,33,44 on consecutive cycles; out_last only on 44; timeout=0.
- Address wrap.
  - Stimulus: load_base=8'hFE, load_len=3.
  - Response: writes at FE, FF, 00; dump of the same window returns the same bytes.
- Backpressure.
  - Stimulus: dump_len=3 with out_ready toggling 0/1 every cycle.
  - Response: out_data stable while stalled; exactly 3 handshakes; returns to IDLE after the final handshake.
- Watchdog.
  - Stimulus: TIMEOUT=16'd20, core_done held 0.
  - Response: exactly 21 RUN cycles with core_reset=0, then timeout=1 and the dump proceeds; the next start clears timeout.
- Zero lengths.
  - Stimulus: load_len=0, dump_len=0.
  - Response: IDLE→RUN directly with no mem_wr_en; after core_done, return to IDLE with no out_valid.
- Mid-load reset.
  - Stimulus: reset=0 after 2 of 4 bytes.
  - Response: all outputs at reset values in the same cycle; start is accepted normally after reset=1.
